// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit bus CPU: steps each instruction through
// T-states and decodes the control word from step, opcode, flags and halt.
module control_sequencer #(
    parameter int unsigned STEPS     = 5,
    parameter bit          EARLY_END = 1'b1
) (
    input  logic        i_CLOCK,
    input  logic        i_CLEAR_n,
    input  logic [3:0]  i_OPCODE,
    input  logic        i_CARRY,
    input  logic        i_ZERO,
    output logic [15:0] o_CONTROL,
    output logic [2:0]  o_STEP,
    output logic        o_HALT
);

    localparam int unsigned SW = $clog2(STEPS);

    localparam int unsigned B_HLT = 15;
    localparam int unsigned B_MI  = 14;
    localparam int unsigned B_RI  = 13;
    localparam int unsigned B_RO  = 12;
    localparam int unsigned B_IO  = 11;
    localparam int unsigned B_II  = 10;
    localparam int unsigned B_AI  = 9;
    localparam int unsigned B_AO  = 8;
    localparam int unsigned B_EO  = 7;
    localparam int unsigned B_SU  = 6;
    localparam int unsigned B_BI  = 5;
    localparam int unsigned B_OI  = 4;
    localparam int unsigned B_CE  = 3;
    localparam int unsigned B_CO  = 2;
    localparam int unsigned B_J   = 1;
    localparam int unsigned B_FI  = 0;

    localparam logic [15:0] IDLE_WORD = 16'h7FB7;

    localparam logic [SW-1:0] STEP_T0   = '0;
    localparam logic [SW-1:0] STEP_T1   = SW'(1);
    localparam logic [SW-1:0] STEP_T2   = SW'(2);
    localparam logic [SW-1:0] STEP_T3   = SW'(3);
    localparam logic [SW-1:0] STEP_T4   = SW'(4);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    opcode_e        op;
    logic [SW-1:0]  step_q, step_d;
    logic           halt_q, halt_d;
    logic [SW-1:0]  last_step;
    logic           halt_set;
    logic [15:0]    ctrl;

    assign op = opcode_e'(i_OPCODE);

    always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
        if (!i_CLEAR_n) begin
            step_q <= '0;
            halt_q <= 1'b0;
        end else begin
            step_q <= step_d;
            halt_q <= halt_d;
        end
    end

    always_comb begin
        last_step = STEP_T2;
        case (op)
            OP_ADD, OP_SUB: last_step = STEP_T4;
            OP_LDA, OP_STA: last_step = STEP_T3;
            default:        last_step = STEP_T2;
        endcase

        halt_set = !halt_q && (step_q == STEP_T2) && (op == OP_HLT);
        halt_d   = halt_q | halt_set;

        // Halt parks the counter at T3 regardless of EARLY_END so the display is stable.
        if (halt_q || halt_set) begin
            step_d = STEP_T3;
        end else if (step_q == STEP_LAST) begin
            step_d = '0;
        end else if (EARLY_END && (step_q == last_step)) begin
            step_d = '0;
        end else begin
            step_d = step_q + SW'(1);
        end
    end

    always_comb begin
        ctrl = IDLE_WORD;
        if (halt_q) begin
            ctrl[B_HLT] = 1'b1;
        end else begin
            case (step_q)
                STEP_T0: begin
                    ctrl[B_CO] = 1'b0;
                    ctrl[B_MI] = 1'b0;
                end
                STEP_T1: begin
                    ctrl[B_RO] = 1'b0;
                    ctrl[B_II] = 1'b0;
                    ctrl[B_CE] = 1'b1;
                end
                STEP_T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl[B_IO] = 1'b0;
                            ctrl[B_MI] = 1'b0;
                        end
                        OP_LDI: begin
                            ctrl[B_IO] = 1'b0;
                            ctrl[B_AI] = 1'b0;
                        end
                        OP_JMP: begin
                            ctrl[B_IO] = 1'b0;
                            ctrl[B_J]  = 1'b0;
                        end
                        OP_JC: begin
                            ctrl[B_IO] = !i_CARRY;
                            ctrl[B_J]  = !i_CARRY;
                        end
                        OP_JZ: begin
                            ctrl[B_IO] = !i_ZERO;
                            ctrl[B_J]  = !i_ZERO;
                        end
                        OP_OUT: begin
                            ctrl[B_AO] = 1'b0;
                            ctrl[B_OI] = 1'b0;
                        end
                        default: ;
                    endcase
                end
                STEP_T3: begin
                    case (op)
                        OP_LDA: begin
                            ctrl[B_RO] = 1'b0;
                            ctrl[B_AI] = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl[B_RO] = 1'b0;
                            ctrl[B_BI] = 1'b0;
                        end
                        OP_STA: begin
                            ctrl[B_AO] = 1'b0;
                            ctrl[B_RI] = 1'b0;
                        end
                        default: ;
                    endcase
                end
                STEP_T4: begin
                    if (op == OP_ADD || op == OP_SUB) begin
                        ctrl[B_EO] = 1'b0;
                        ctrl[B_AI] = 1'b0;
                        ctrl[B_FI] = 1'b0;
                        ctrl[B_SU] = (op == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_CONTROL = ctrl;
    assign o_STEP    = step_q[2:0];
    assign o_HALT    = halt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one early-end instance (STEPS=5) and one
// full-length instance (STEPS=6) share clock and inputs.
module tb_control_sequencer;

    logic        clk;
    logic        clear_n;
    logic [3:0]  opcode;
    logic        carry;
    logic        zero;

    logic [15:0] ctrl1, ctrl0;
    logic [2:0]  step1, step0;
    logic        halt1, halt0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    control_sequencer #(.STEPS(5), .EARLY_END(1'b1)) dut (
        .i_CLOCK   (clk),
        .i_CLEAR_n (clear_n),
        .i_OPCODE  (opcode),
        .i_CARRY   (carry),
        .i_ZERO    (zero),
        .o_CONTROL (ctrl1),
        .o_STEP    (step1),
        .o_HALT    (halt1)
    );

    control_sequencer #(.STEPS(6), .EARLY_END(1'b0)) dut0 (
        .i_CLOCK   (clk),
        .i_CLEAR_n (clear_n),
        .i_OPCODE  (opcode),
        .i_CARRY   (carry),
        .i_ZERO    (zero),
        .o_CONTROL (ctrl0),
        .o_STEP    (step0),
        .o_HALT    (halt0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 clear_n = 1'b0;
        #2 clear_n = 1'b1;
    endtask

    initial begin
        clear_n = 1'b0;
        opcode  = 4'h0;
        carry   = 1'b0;
        zero    = 1'b0;
        #1;
        chk("rst_ctrl", ctrl1, 16'h3FB3);
        chk("rst_step", {13'b0, step1}, 16'd0);
        chk("rst_halt", {15'b0, halt1}, 16'd0);
        chk("rst_ctrl0", ctrl0, 16'h3FB3);
        #1 clear_n = 1'b1;

        // ADD, then asynchronous reset in the middle of T3
        opcode = 4'h2;
        tick();
        chk("add_t1", ctrl1, 16'h6BBF);
        chk("add_t1_step", {13'b0, step1}, 16'd1);
        tick();
        chk("add_t2", ctrl1, 16'h37B7);
        tick();
        chk("add_t3", ctrl1, 16'h6F97);
        chk("add_t3_step", {13'b0, step1}, 16'd3);
        #2 clear_n = 1'b0;
        #1;
        chk("midrst_step", {13'b0, step1}, 16'd0);
        chk("midrst_ctrl", ctrl1, 16'h3FB3);
        chk("midrst_halt", {15'b0, halt1}, 16'd0);
        #1 clear_n = 1'b1;

        // SUB full instruction
        opcode = 4'h3;
        tick();
        tick();
        chk("sub_t2", ctrl1, 16'h37B7);
        tick();
        chk("sub_t3", ctrl1, 16'h6F97);
        tick();
        chk("sub_t4", ctrl1, 16'h7D76);
        chk("sub_t4_full", ctrl0, 16'h7D76);
        tick();
        chk("sub_end_step", {13'b0, step1}, 16'd0);
        chk("sub_end_ctrl", ctrl1, 16'h3FB3);
        chk("sub_t5_full", ctrl0, 16'h7FB7);
        chk("sub_t5_full_step", {13'b0, step0}, 16'd5);
        tick();
        chk("sub_full_wrap", {13'b0, step0}, 16'd0);

        // LDA on both instances
        do_reset();
        opcode = 4'h1;
        chk("lda_t0_step", {13'b0, step1}, 16'd0);
        tick();
        chk("lda_t1_step", {13'b0, step1}, 16'd1);
        tick();
        chk("lda_t2", ctrl1, 16'h37B7);
        chk("lda_t2_step", {13'b0, step1}, 16'd2);
        tick();
        chk("lda_t3", ctrl1, 16'h6DB7);
        chk("lda_t3_step", {13'b0, step1}, 16'd3);
        tick();
        chk("lda_end_step", {13'b0, step1}, 16'd0);
        chk("lda_t4_full", ctrl0, 16'h7FB7);
        chk("lda_t4_full_step", {13'b0, step0}, 16'd4);
        tick();
        chk("lda_t5_full", ctrl0, 16'h7FB7);
        tick();
        chk("lda_full_wrap", {13'b0, step0}, 16'd0);
        chk("lda_full_t0", ctrl0, 16'h3FB3);

        // JC with carry clear, then set, then flag change inside T2
        do_reset();
        opcode = 4'h7;
        carry  = 1'b0;
        tick();
        tick();
        chk("jc0_t2", ctrl1, 16'h7FB7);
        tick();
        chk("jc0_end_step", {13'b0, step1}, 16'd0);
        do_reset();
        carry = 1'b1;
        tick();
        tick();
        chk("jc1_t2", ctrl1, 16'h77B5);
        carry = 1'b0;
        #1;
        chk("jc_drop_t2", ctrl1, 16'h7FB7);
        carry = 1'b1;
        #1;
        chk("jc_rise_t2", ctrl1, 16'h77B5);
        tick();
        chk("jc1_end_step", {13'b0, step1}, 16'd0);

        // JZ, STA, LDI, OUT, JMP spot checks
        do_reset();
        opcode = 4'h8;
        zero   = 1'b1;
        tick();
        tick();
        chk("jz1_t2", ctrl1, 16'h77B5);
        zero = 1'b0;
        #1;
        chk("jz0_t2", ctrl1, 16'h7FB7);
        do_reset();
        opcode = 4'h4;
        tick();
        tick();
        chk("sta_t2", ctrl1, 16'h37B7);
        tick();
        chk("sta_t3", ctrl1, 16'h5EB7);
        do_reset();
        opcode = 4'h5;
        tick();
        tick();
        chk("ldi_t2", ctrl1, 16'h75B7);
        tick();
        chk("ldi_end_step", {13'b0, step1}, 16'd0);
        do_reset();
        opcode = 4'hE;
        tick();
        tick();
        chk("out_t2", ctrl1, 16'h7EA7);
        do_reset();
        opcode = 4'h6;
        tick();
        tick();
        chk("jmp_t2", ctrl1, 16'h77B5);

        // Undefined opcode 1010
        do_reset();
        opcode = 4'hA;
        chk("undef_t0", ctrl1, 16'h3FB3);
        tick();
        chk("undef_t1", ctrl1, 16'h6BBF);
        tick();
        chk("undef_t2", ctrl1, 16'h7FB7);
        chk("undef_t2_step", {13'b0, step1}, 16'd2);
        tick();
        chk("undef_end_step", {13'b0, step1}, 16'd0);

        // HLT, frozen while halted, released only by clear
        do_reset();
        opcode = 4'hF;
        tick();
        tick();
        chk("hlt_t2", ctrl1, 16'h7FB7);
        chk("hlt_t2_halt", {15'b0, halt1}, 16'd0);
        tick();
        chk("hlt_halt", {15'b0, halt1}, 16'd1);
        chk("hlt_ctrl", ctrl1, 16'hFFB7);
        chk("hlt_step", {13'b0, step1}, 16'd3);
        chk("hlt_full_halt", {15'b0, halt0}, 16'd1);
        chk("hlt_full_step", {13'b0, step0}, 16'd3);
        for (int i = 0; i < 10; i++) begin
            opcode = 4'(i);
            carry  = ~carry;
            zero   = ~zero;
            tick();
            chk("halted_step", {13'b0, step1}, 16'd3);
            chk("halted_ctrl", ctrl1, 16'hFFB7);
        end
        clear_n = 1'b0;
        #1;
        chk("unhalt_halt", {15'b0, halt1}, 16'd0);
        chk("unhalt_step", {13'b0, step1}, 16'd0);
        chk("unhalt_ctrl", ctrl1, 16'h3FB3);
        #1 clear_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
